// File: rtl/lifo_arbiter.sv
// Two-requester round-robin arbiter that serialises push/pop operations onto an
// external LIFO stack and keeps the word count for it.
module lifo_arbiter #(
  parameter int BUS_WIDTH  = 16,
  parameter int STACK_SIZE = 16,
  localparam int CW = $clog2(STACK_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 op_a,
  input  logic                 op_b,
  input  logic [BUS_WIDTH-1:0] wdata_a,
  input  logic [BUS_WIDTH-1:0] wdata_b,
  output logic                 ack_a,
  output logic                 ack_b,
  output logic                 err_a,
  output logic                 err_b,
  output logic [BUS_WIDTH-1:0] rdata_a,
  output logic [BUS_WIDTH-1:0] rdata_b,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [BUS_WIDTH-1:0] stk_data_in,
  input  logic [BUS_WIDTH-1:0] stk_data_out,
  output logic                 stk_reset,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t               state;
  logic                 grant_b;
  logic                 last_b;
  logic                 op_q;
  logic                 accept_q;
  logic [BUS_WIDTH-1:0] resp_q;
  logic [1:0]           rst_sync;

  logic                 pick_b;
  logic                 sel_op;
  logic                 sel_accept;
  logic [BUS_WIDTH-1:0] sel_wdata;

  // B wins only if A is absent or A was the most recent grant.
  assign pick_b     = req_b & (~req_a | ~last_b);
  assign sel_op     = pick_b ? op_b : op_a;
  assign sel_wdata  = pick_b ? wdata_b : wdata_a;
  assign sel_accept = sel_op ? ~full : ~empty;

  assign full  = (count == CW'(STACK_SIZE));
  assign empty = (count == '0);

  // Stack reset asserts with the block and releases one full cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign stk_reset = ~rst_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant_b     <= 1'b0;
      last_b      <= 1'b1;
      op_q        <= 1'b0;
      accept_q    <= 1'b0;
      resp_q      <= '0;
      count       <= '0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      err_a       <= 1'b0;
      err_b       <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
    end else begin
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      err_a       <= 1'b0;
      err_b       <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;

      case (state)
        IDLE: begin
          // Accept/reject is decided here so the strobe can be registered into ISSUE.
          if (req_a | req_b) begin
            grant_b     <= pick_b;
            op_q        <= sel_op;
            accept_q    <= sel_accept;
            stk_push    <= sel_op & sel_accept;
            stk_pop     <= ~sel_op & sel_accept;
            stk_data_in <= (sel_op & sel_accept) ? sel_wdata : '0;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (accept_q) begin
            if (op_q) begin
              count  <= count + CW'(1);
              resp_q <= '0;
            end else begin
              count  <= count - CW'(1);
              resp_q <= stk_data_out;
            end
            state <= SETTLE;
          end else begin
            ack_a <= ~grant_b;
            ack_b <= grant_b;
            err_a <= ~grant_b;
            err_b <= grant_b;
            state <= RESP;
          end
        end

        SETTLE: begin
          ack_a   <= ~grant_b;
          ack_b   <= grant_b;
          rdata_a <= grant_b ? '0 : resp_q;
          rdata_b <= grant_b ? resp_q : '0;
          state   <= RESP;
        end

        RESP: begin
          last_b <= grant_b;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomised scoreboard bench for lifo_arbiter with an attached behavioural stack
// and a queue-based reference model of the arbitration and stack semantics.
module tb_lifo_arbiter;

  localparam int BW = 16;
  localparam int SS = 16;
  localparam int CW = $clog2(SS) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic          op_a = 1'b0, op_b = 1'b0;
  logic [BW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, err_a, err_b;
  logic [BW-1:0] rdata_a, rdata_b;
  logic          stk_push, stk_pop, stk_reset;
  logic [BW-1:0] stk_data_in, stk_data_out;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clk = ~clk;

  lifo_arbiter #(.BUS_WIDTH(BW), .STACK_SIZE(SS)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_reset(stk_reset), .count(count), .full(full), .empty(empty)
  );

  // Attached stack: top-of-stack is visible combinationally.
  logic [BW-1:0] stack_mem [0:SS-1];
  int            sp;

  always @(posedge clk or posedge stk_reset) begin
    if (stk_reset) begin
      sp <= 0;
    end else if (stk_push && sp < SS) begin
      stack_mem[sp] <= stk_data_in;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  assign stk_data_out = (sp > 0) ? stack_mem[sp-1] : '0;

  typedef struct {
    bit            who_b;
    bit            err;
    bit            is_pop;
    logic [BW-1:0] rdata;
    int            cnt;
    int            cyc;
  } resp_t;

  typedef struct {
    bit            push;
    logic [BW-1:0] data;
    int            cyc;
  } strb_t;

  resp_t         sb[$];
  strb_t         sq[$];
  logic [BW-1:0] model_stack[$];
  bit            m_last_b = 1'b1;
  bit            pend_a = 1'b0, pend_b = 1'b0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  resp_t         mon_e;
  strb_t         mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pops on strobes and acks.
  always @(negedge clk) begin
    if (!ack_a) begin
      check_output("rdata_a_quiet", 32'(rdata_a), 32'd0);
      check_output("err_a_quiet", 32'(err_a), 32'd0);
    end
    if (!ack_b) begin
      check_output("rdata_b_quiet", 32'(rdata_b), 32'd0);
      check_output("err_b_quiet", 32'(err_b), 32'd0);
    end
    if (stk_push || stk_pop) begin
      check_output("strobe_excl", 32'(stk_push & stk_pop), 32'd0);
      if (sq.size() == 0) begin
        fail_event("unexpected_strobe", "actual strobe, required none");
      end else begin
        mon_s = sq.pop_front();
        check_output("strobe_kind", 32'(stk_push), 32'(mon_s.push));
        if (mon_s.push) check_output("stk_data_in", 32'(stk_data_in), 32'(mon_s.data));
        check_output("strobe_cycle", 32'(cyc), 32'(mon_s.cyc));
      end
    end
    if (ack_a || ack_b) begin
      if (sb.size() == 0) begin
        fail_event("unexpected_ack", "actual ack, required none");
      end else begin
        mon_e = sb.pop_front();
        check_output("ack_requester", {30'd0, ack_a, ack_b}, mon_e.who_b ? 32'd1 : 32'd2);
        check_output("err", 32'(mon_e.who_b ? err_b : err_a), 32'(mon_e.err));
        if (mon_e.err || mon_e.is_pop)
          check_output("rdata", 32'(mon_e.who_b ? rdata_b : rdata_a), 32'(mon_e.rdata));
        check_output("count", 32'(count), 32'(mon_e.cnt));
        check_output("full", 32'(full), 32'(mon_e.cnt == SS));
        check_output("empty", 32'(empty), 32'(mon_e.cnt == 0));
        check_output("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic raise_a(input bit op, input logic [BW-1:0] d);
    req_a = 1'b1; op_a = op; wdata_a = d; pend_a = 1'b1;
  endtask

  task automatic raise_b(input bit op, input logic [BW-1:0] d);
    req_b = 1'b1; op_b = op; wdata_b = d; pend_b = 1'b1;
  endtask

  // Predicts the next grant and its outcome, then waits for that ack and drops the req.
  task automatic apply_stimulus(input bit toggle);
    bit            wb, op, err, got;
    logic [BW-1:0] d, rd;
    int            issue;
    resp_t         e;
    strb_t         s;
    wb  = pend_b && (!pend_a || !m_last_b);
    op  = wb ? op_b : op_a;
    d   = wb ? wdata_b : wdata_a;
    err = 1'b0;
    rd  = '0;
    if (op) begin
      if (model_stack.size() == SS) err = 1'b1;
      else model_stack.push_back(d);
    end else begin
      if (model_stack.size() == 0) err = 1'b1;
      else rd = model_stack.pop_back();
    end
    issue = cyc + 1;
    if (!err) begin
      s.push = op; s.data = op ? d : '0; s.cyc = issue;
      sq.push_back(s);
    end
    e.who_b = wb; e.err = err; e.is_pop = !op; e.rdata = rd;
    e.cnt = model_stack.size(); e.cyc = issue + (err ? 1 : 2);
    sb.push_back(e);
    m_last_b = wb;
    if (toggle) begin
      @(posedge clk); #1;
      if (wb) begin op_b = !op_b; wdata_b = ~wdata_b; end
      else begin op_a = !op_a; wdata_a = ~wdata_a; end
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = wb ? ack_b : ack_a;
    end
    if (!got) fail_event("ack_timeout", "actual no ack, required ack within 8 cycles");
    @(posedge clk); #1;
    if (wb) begin req_b = 1'b0; pend_b = 1'b0; end
    else begin req_a = 1'b0; pend_a = 1'b0; end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
    wdata_a = '0; wdata_b = '0; pend_a = 1'b0; pend_b = 1'b0;
    model_stack.delete();
    m_last_b = 1'b1;
    @(negedge clk);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_acks", {28'd0, ack_a, ack_b, err_a, err_b}, 32'd0);
    check_output("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    check_output("rst_stk_data_in", 32'(stk_data_in), 32'd0);
    check_output("rst_stk_reset", 32'(stk_reset), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_output("stk_reset_hold", 32'(stk_reset), 32'd1);
    @(negedge clk);
    check_output("stk_reset_release", 32'(stk_reset), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_reset();

    // Pop on empty after reset, then push/pop handoff between requesters.
    raise_a(1'b0, '0);         apply_stimulus(1'b0);
    raise_a(1'b1, 16'h1234);   apply_stimulus(1'b0);
    raise_b(1'b0, '0);         apply_stimulus(1'b0);

    // Continuous contention from reset must alternate A, B, A, B.
    apply_reset();
    raise_a(1'b1, 16'h0A00);
    raise_b(1'b1, 16'h0B00);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0);
      if (!pend_a) raise_a(1'b1, 16'(16'h0A01 + i));
      else         raise_b(1'b1, 16'(16'h0B01 + i));
    end
    while (pend_a || pend_b) apply_stimulus(1'b0);

    // Fill, overflow, drain, underflow.
    apply_reset();
    for (int i = 0; i < SS; i++) begin
      raise_a(1'b1, 16'(i));
      apply_stimulus(1'b0);
    end
    raise_a(1'b1, 16'hFFFF);   apply_stimulus(1'b0);
    check_output("full_after_fill", 32'(full), 32'd1);
    for (int i = 0; i < SS; i++) begin
      raise_b(1'b0, '0);
      apply_stimulus(1'b0);
    end
    check_output("empty_after_drain", 32'(empty), 32'd1);
    raise_b(1'b0, '0);         apply_stimulus(1'b0);

    // Op/data changes after the grant must be ignored.
    raise_b(1'b1, 16'hA5A5);   apply_stimulus(1'b0);
    raise_a(1'b0, 16'h0000);   apply_stimulus(1'b1);
    raise_a(1'b1, 16'h7777);   apply_stimulus(1'b1);

    // Reset during SETTLE of a push aborts it without an ack.
    raise_a(1'b1, 16'hBEEF);
    sq.push_back('{1'b1, 16'hBEEF, cyc + 1});
    @(posedge clk);
    @(posedge clk);
    apply_reset();

    for (int r = 0; r < 60; r++) begin
      if (!pend_a && $urandom_range(1, 0) == 1) raise_a(1'($urandom_range(1, 0)), 16'($urandom));
      if (!pend_b && $urandom_range(1, 0) == 1) raise_b(1'($urandom_range(1, 0)), 16'($urandom));
      if (!pend_a && !pend_b) raise_a(1'($urandom_range(1, 0)), 16'($urandom));
      apply_stimulus(1'($urandom_range(7, 0) == 0));
    end
    while (pend_a || pend_b) apply_stimulus(1'b0);

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    check_output("strobes_drained", 32'(sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
